// File: rtl/imem_loader.sv
// imem_loader: programs the instruction memory from a byte stream (16-bit LE word count, then LE words).
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR-of-data checksum byte.
module imem_loader #(
  parameter int MEMORY_SIZE = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CSUM;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  localparam logic [CNT_W-1:0] MEM_WORDS = CNT_W'(MEMORY_SIZE);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, word_idx_r, words_loaded_r, hdr_count_s;
  logic [1:0]       byte_idx_r;
  logic [23:0]      word_buf_r;
  logic [31:0]      mem_addr_r, mem_wdata_r;
  logic             in_ready_r, mem_we_r, cpu_hold_r, busy_r, done_r, err_r;
  logic             start_ok_s, accept_s, word_end_s, last_word_s, busy_s, in_range_s;

  function automatic logic [31:0] word_byte_addr(input logic [CNT_W-1:0] idx);
    word_byte_addr = 32'(idx) << 2'd2;
  endfunction

  assign hdr_count_s = CNT_W'({in_data, count_r[7:0]});
  assign in_range_s  = (word_idx_r < MEM_WORDS);

  // Next-state decode and per-cycle strobes
  always_comb begin
    state_s     = state_r;
    start_ok_s  = 1'b0;
    accept_s    = in_valid && in_ready_r;
    word_end_s  = (state_r == S_DATA) && accept_s && (byte_idx_r == 2'd3);
    last_word_s = word_end_s && ((word_idx_r + CNT_W'(1)) == count_r);
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s    = S_HDR0;
          start_ok_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_HDR0: begin
        if (accept_s) state_s = S_HDR1;
        else          state_s = S_HDR0;
      end
      S_HDR1: begin
        if (accept_s && (hdr_count_s == {CNT_W{1'b0}})) state_s = END_STATE;
        else if (accept_s)                             state_s = S_DATA;
        else                                           state_s = S_HDR1;
      end
      S_DATA: begin
        if (last_word_s) state_s = END_STATE;
        else             state_s = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) state_s = S_DONE;
        else          state_s = S_CSUM;
      end
`endif
      default: state_s = S_IDLE;
    endcase
    busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_r;

  // Running XOR of data bytes (header excluded)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'd0;
    end else if (start_ok_s) begin
      csum_r <= 8'd0;
    end else if (accept_s && (state_r == S_DATA)) begin
      csum_r <= csum_r ^ in_data;
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // Header capture, word assembly, memory write and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r        <= {CNT_W{1'b0}};
      word_idx_r     <= {CNT_W{1'b0}};
      words_loaded_r <= {CNT_W{1'b0}};
      byte_idx_r     <= 2'd0;
      word_buf_r     <= 24'd0;
      mem_addr_r     <= 32'd0;
      mem_wdata_r    <= 32'd0;
      mem_we_r       <= 1'b0;
      in_ready_r     <= 1'b0;
      busy_r         <= 1'b0;
      cpu_hold_r     <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      mem_we_r   <= 1'b0;
      in_ready_r <= busy_s;
      busy_r     <= busy_s;
      if (start_ok_s) begin
        count_r        <= {CNT_W{1'b0}};
        word_idx_r     <= {CNT_W{1'b0}};
        words_loaded_r <= {CNT_W{1'b0}};
        byte_idx_r     <= 2'd0;
        word_buf_r     <= 24'd0;
        cpu_hold_r     <= 1'b1;
        done_r         <= 1'b0;
        err_r          <= 1'b0;
      end else begin
        // Entering DONE is one cycle behind the last write so cpu_hold covers it
        if (state_r == S_DONE) begin
          done_r     <= 1'b1;
          cpu_hold_r <= 1'b0;
        end
        if (accept_s) begin
          case (state_r)
            S_HDR0: count_r <= CNT_W'(in_data);
            S_HDR1: count_r <= hdr_count_s;
            S_DATA: begin
              byte_idx_r <= byte_idx_r + 2'd1;
              case (byte_idx_r)
                2'd0: word_buf_r[7:0]   <= in_data;
                2'd1: word_buf_r[15:8]  <= in_data;
                2'd2: word_buf_r[23:16] <= in_data;
                2'd3: begin
                  word_idx_r <= word_idx_r + CNT_W'(1);
                  if (in_range_s) begin
                    mem_we_r       <= 1'b1;
                    mem_addr_r     <= word_byte_addr(word_idx_r);
                    mem_wdata_r    <= {in_data, word_buf_r};
                    words_loaded_r <= words_loaded_r + CNT_W'(1);
                  end else begin
                    err_r <= 1'b1;
                  end
                end
                default: word_buf_r <= word_buf_r;
              endcase
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
              if (in_data != csum_r) err_r <= 1'b1;
            end
`endif
            default: count_r <= count_r;
          endcase
        end
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign cpu_hold     = cpu_hold_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum steps run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_ready, mem_we, cpu_hold, busy, done, err;
  logic [7:0]  in_data;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  prog2 [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};

  imem_loader #(.MEMORY_SIZE(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write strobe away from the active edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hff;
      tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    assert (acc) else begin
      n_err++;
      $error("FAIL byte_accept_timeout: observed in_ready never 1 expected byte %02h accepted", b);
    end
  endtask

  task automatic send_stream2(input bit gap, input int start_at);
    for (int i = 0; i < 10; i++) begin
      if (i == start_at) pulse_start();
      send_byte(prog2[i], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h70, gap);
`endif
  endtask

  task automatic check_prog2(input string pfx);
    tick();
    check({pfx, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
    check({pfx, "_a0"}, wr_addr_q[0], 32'h0000_0000);
    check({pfx, "_d0"}, wr_data_q[0], 32'h0050_0513);
    check({pfx, "_a1"}, wr_addr_q[1], 32'h0000_0004);
    check({pfx, "_d1"}, wr_data_q[1], 32'h00a0_0593);
    check({pfx, "_wl"}, 32'(words_loaded), 32'd2);
    check({pfx, "_done"}, 32'(done), 32'd1);
    check({pfx, "_err"}, 32'(err), 32'd0);
    check({pfx, "_hold"}, 32'(cpu_hold), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_rdy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic clear_q();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rdy"}, 32'(in_ready), 32'd0);
    check({pfx, "_we"}, 32'(mem_we), 32'd0);
    check({pfx, "_addr"}, mem_addr, 32'd0);
    check({pfx, "_wdata"}, mem_wdata, 32'd0);
    check({pfx, "_hold"}, 32'(cpu_hold), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_err"}, 32'(err), 32'd0);
    check({pfx, "_wl"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    logic [7:0] xs;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Bytes offered while idle must not be taken
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    check("idle_rdy", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // Basic two-word load
    clear_q();
    pulse_start();
    check("t1_hold_start", 32'(cpu_hold), 32'd1);
    check("t1_busy_start", 32'(busy), 32'd1);
    check("t1_rdy_start", 32'(in_ready), 32'd1);
    send_stream2(1'b0, -1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t1_last_we", 32'(mem_we), 32'd1);
`endif
    check("t1_last_hold", 32'(cpu_hold), 32'd1);
    check("t1_last_done", 32'(done), 32'd0);
    check_prog2("t1");

    // Same load with in_valid toggling
    clear_q();
    pulse_start();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_wl_clr", 32'(words_loaded), 32'd0);
    send_stream2(1'b1, -1);
    check_prog2("t2");

    // start pulsed mid-load is ignored
    clear_q();
    pulse_start();
    send_stream2(1'b0, 5);
    check_prog2("t3");

    // Zero-word load
    clear_q();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    tick();
    check("t4_nwr", 32'(wr_addr_q.size()), 32'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_err", 32'(err), 32'd0);
    check("t4_wl", 32'(words_loaded), 32'd0);

    // 33 words into a 32-word memory
    clear_q();
    pulse_start();
    send_byte(8'h21, 1'b0);
    send_byte(8'h00, 1'b0);
    xs = 8'h00;
    for (int i = 0; i < 33; i++) begin
      send_byte(8'(i), 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      xs = xs ^ 8'(i) ^ 8'h11 ^ 8'h22 ^ 8'h33;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xs, 1'b0);
`endif
    tick();
    check("t5_nwr", 32'(wr_addr_q.size()), 32'd32);
    check("t5_a0", wr_addr_q[0], 32'h0000_0000);
    check("t5_d0", wr_data_q[0], 32'h3322_1100);
    check("t5_alast", wr_addr_q[31], 32'h0000_007c);
    check("t5_dlast", wr_data_q[31], 32'h3322_111f);
    check("t5_wl", 32'(words_loaded), 32'd32);
    check("t5_err", 32'(err), 32'd1);
    check("t5_done", 32'(done), 32'd1);

    // Reset after six bytes, then a clean reload
    clear_q();
    pulse_start();
    check("t6_err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 6; i++) send_byte(prog2[i], 1'b0);
    rst_n = 1'b0;
    #2;
    check_all_zero("t6_rst");
    rst_n = 1'b1;
    tick();
    clear_q();
    pulse_start();
    send_stream2(1'b0, -1);
    check_prog2("t6");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good and bad trailing checksum
    clear_q();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h0f, 1'b0);
    tick();
    check("t7_nwr", 32'(wr_addr_q.size()), 32'd1);
    check("t7_d0", wr_data_q[0], 32'h0804_0201);
    check("t7_err", 32'(err), 32'd0);
    check("t7_done", 32'(done), 32'd1);
    clear_q();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h0e, 1'b0);
    tick();
    check("t8_nwr", 32'(wr_addr_q.size()), 32'd1);
    check("t8_a0", wr_addr_q[0], 32'h0000_0000);
    check("t8_d0", wr_data_q[0], 32'h0804_0201);
    check("t8_err", 32'(err), 32'd1);
    check("t8_done", 32'(done), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
